iiitb_elc_scan: RTL and testbench

Parametrised multi-request elevator controller, the next generation of `iiitb_elc`. It latches any number of floor calls into a pending bitmap and serves them in SCAN (sweep) order. Floor travel and door dwell are timed. The door and weight interlocks hold the car at a floor. It sits between the call-button/sensor front end and the motor/door drivers. All outputs are registered.

---
 rtl/iiitb_elc_scan.sv | 175 +++++++++++++++++
 tb/tb_iiitb_elc_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_elc_scan.sv
// SCAN-order elevator controller: latches any number of floor calls into a pending
// bitmap, sweeps in one direction until nothing lies ahead, then reverses.
module iiitb_elc_scan #(
    parameter int FLOORS      = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] request_floor,
    input  logic              over_time,
    input  logic              over_weight,
    output logic [FLOORS-1:0] out_current_floor,
    output logic              direction,
    output logic              moving,
    output logic              door_open,
    output logic              complete,
    output logic [FLOORS-1:0] pending,
    output logic              door_alert,
    output logic              weight_alert
);

    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DOOR_LAST  = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [FLOORS-1:0] FLOOR_BASE = FLOORS'(1);
    localparam logic [FLOORS-1:0] NO_FLOORS  = {FLOORS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [FLOORS-1:0] floor_r, floor_s;
    logic              dir_r, dir_s;
    logic [FLOORS-1:0] pending_r, pending_s;
    logic [CNT_W-1:0]  step_cnt_r, step_cnt_s;
    logic [CNT_W-1:0]  door_cnt_r, door_cnt_s;
    logic              moving_r, moving_s;
    logic              door_open_r, door_open_s;
    logic              complete_r, complete_s;
    logic              door_alert_r, door_alert_s;
    logic              weight_alert_r, weight_alert_s;

    logic [FLOORS-1:0] below_s;
    logic [FLOORS-1:0] above_s;
    logic [FLOORS-1:0] ahead_s;
    logic [FLOORS-1:0] behind_s;
    logic [FLOORS-1:0] latch_mask_s;
    logic [FLOORS-1:0] clear_s;
    logic              cur_pend_s;
    logic              cur_req_s;

    // State and output registers, all with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            floor_r        <= FLOOR_BASE;
            dir_r          <= 1'b1;
            pending_r      <= NO_FLOORS;
            step_cnt_r     <= CNT_ZERO;
            door_cnt_r     <= CNT_ZERO;
            moving_r       <= 1'b0;
            door_open_r    <= 1'b0;
            complete_r     <= 1'b0;
            door_alert_r   <= 1'b0;
            weight_alert_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            floor_r        <= floor_s;
            dir_r          <= dir_s;
            pending_r      <= pending_s;
            step_cnt_r     <= step_cnt_s;
            door_cnt_r     <= door_cnt_s;
            moving_r       <= moving_s;
            door_open_r    <= door_open_s;
            complete_r     <= complete_s;
            door_alert_r   <= door_alert_s;
            weight_alert_r <= weight_alert_s;
        end
    end

    // Next-state, position, direction, counters and pending bitmap
    always_comb begin
        // floor_r is one-hot, so subtracting one yields every floor strictly below it
        below_s      = floor_r - FLOOR_BASE;
        above_s      = ~(below_s | floor_r);
        ahead_s      = dir_r ? (pending_r & above_s) : (pending_r & below_s);
        behind_s     = dir_r ? (pending_r & below_s) : (pending_r & above_s);
        cur_pend_s   = |(pending_r & floor_r);
        cur_req_s    = |(request_floor & floor_r);

        state_s      = state_r;
        floor_s      = floor_r;
        dir_s        = dir_r;
        step_cnt_s   = step_cnt_r;
        door_cnt_s   = door_cnt_r;
        clear_s      = NO_FLOORS;
        latch_mask_s = request_floor;

        case (state_r)
            ST_IDLE: begin
                if (over_weight) begin
                    state_s = ST_IDLE;
                end else if (cur_pend_s) begin
                    state_s    = ST_DOOR;
                    door_cnt_s = CNT_ZERO;
                    clear_s    = floor_r;
                end else if (|ahead_s) begin
                    state_s    = ST_MOVE;
                    step_cnt_s = CNT_ZERO;
                end else if (|behind_s) begin
                    dir_s      = ~dir_r;
                    state_s    = ST_MOVE;
                    step_cnt_s = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (step_cnt_r == STEP_LAST) begin
                    floor_s    = dir_r ? {floor_r[FLOORS-2:0], 1'b0} : {1'b0, floor_r[FLOORS-1:1]};
                    step_cnt_s = CNT_ZERO;
                    state_s    = ST_IDLE;
                end else begin
                    step_cnt_s = step_cnt_r + CNT_ONE;
                end
            end
            ST_DOOR: begin
                // A call for the floor we are standing at just keeps the door open
                latch_mask_s = request_floor & ~floor_r;
                if (over_time || over_weight || cur_req_s) begin
                    door_cnt_s = CNT_ZERO;
                end else if (door_cnt_r == DOOR_LAST) begin
                    door_cnt_s = CNT_ZERO;
                    state_s    = ST_IDLE;
                end else begin
                    door_cnt_s = door_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                step_cnt_s = CNT_ZERO;
                door_cnt_s = CNT_ZERO;
            end
        endcase

        pending_s = (pending_r | latch_mask_s) & ~clear_s;
    end

    // Output values for the state being entered; alerts use the sensors sampled on that edge
    always_comb begin
        moving_s       = (state_s == ST_MOVE);
        door_open_s    = (state_s == ST_DOOR);
        complete_s     = (state_r == ST_IDLE) && (state_s == ST_DOOR);
        door_alert_s   = (state_s == ST_DOOR) && over_time;
        weight_alert_s = ((state_s == ST_IDLE) || (state_s == ST_DOOR)) && over_weight;
    end

    assign out_current_floor = floor_r;
    assign direction         = dir_r;
    assign pending           = pending_r;
    assign moving            = moving_r;
    assign door_open         = door_open_r;
    assign complete          = complete_r;
    assign door_alert        = door_alert_r;
    assign weight_alert      = weight_alert_r;

endmodule

// File: tb/tb_iiitb_elc_scan.sv
// Bench for iiitb_elc_scan: directed scenarios plus random traffic, every cycle
// compared against a floor-index/countdown reference model.
module tb_iiitb_elc_scan;

    localparam int F  = 8;
    localparam int MC = 2;
    localparam int DC = 4;

    localparam int M_IDLE   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DOOR   = 2;

    logic         clk;
    logic         reset;
    logic [F-1:0] request_floor;
    logic         over_time;
    logic         over_weight;
    logic [F-1:0] out_current_floor;
    logic         direction;
    logic         moving;
    logic         door_open;
    logic         complete;
    logic [F-1:0] pending;
    logic         door_alert;
    logic         weight_alert;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model state
    int           m_floor;
    bit           m_dir;
    logic [F-1:0] m_pend;
    int           m_mode;
    int           m_left;
    bit           m_complete;
    bit           m_dalert;
    bit           m_walert;

    iiitb_elc_scan #(.FLOORS(F), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
        .clk               (clk),
        .reset             (reset),
        .request_floor     (request_floor),
        .over_time         (over_time),
        .over_weight       (over_weight),
        .out_current_floor (out_current_floor),
        .direction         (direction),
        .moving            (moving),
        .door_open         (door_open),
        .complete          (complete),
        .pending           (pending),
        .door_alert        (door_alert),
        .weight_alert      (weight_alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs sampled on it
    task automatic model_step(input logic rst, input logic [F-1:0] req, input logic ot, input logic ow);
        logic [F-1:0] nxt;
        bit ahead;
        bit any_call;
        m_complete = 1'b0;
        if (rst) begin
            m_floor = 0; m_dir = 1'b1; m_pend = '0; m_mode = M_IDLE; m_left = 0;
            m_dalert = 1'b0; m_walert = 1'b0;
            return;
        end
        nxt = m_pend | req;
        if (m_mode == M_DOOR) nxt[m_floor] = m_pend[m_floor];
        case (m_mode)
            M_IDLE: begin
                if (!ow) begin
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR; m_left = DC; nxt[m_floor] = 1'b0; m_complete = 1'b1;
                    end else begin
                        ahead = 1'b0; any_call = 1'b0;
                        for (int i = 0; i < F; i++) begin
                            if (m_pend[i]) begin
                                any_call = 1'b1;
                                if (m_dir ? (i > m_floor) : (i < m_floor)) ahead = 1'b1;
                            end
                        end
                        if (any_call) begin
                            if (!ahead) m_dir = !m_dir;
                            m_mode = M_TRAVEL; m_left = MC;
                        end
                    end
                end
            end
            M_TRAVEL: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    m_mode = M_IDLE;
                end
            end
            default: begin
                if (ot || ow || req[m_floor]) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
        m_pend   = nxt;
        m_dalert = (m_mode == M_DOOR) && ot;
        m_walert = (m_mode != M_TRAVEL) && ow;
    endtask

    task automatic compare_all();
        logic [F-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[m_floor] = 1'b1;
        check("floor",        out_current_floor, exp_oh);
        check("direction",    direction,         m_dir);
        check("pending",      pending,           m_pend);
        check("moving",       moving,            m_mode == M_TRAVEL);
        check("door_open",    door_open,         m_mode == M_DOOR);
        check("complete",     complete,          m_complete);
        check("door_alert",   door_alert,        m_dalert);
        check("weight_alert", weight_alert,      m_walert);
    endtask

    task automatic tick();
        model_step(reset, request_floor, over_time, over_weight);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int completes;
        logic [F-1:0] r;
        reset = 1'b1; request_floor = '0; over_time = 1'b0; over_weight = 1'b0;

        // reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_floor",   out_current_floor, 8'h01);
        check("rst_dir",     direction,         1'b1);
        check("rst_pending", pending,           8'h00);
        check("rst_outs", {moving, door_open, complete, door_alert, weight_alert}, 5'b00000);

        // call to floor 3, then floors 6 and 1 latched while the door is open at 3
        request_floor = 8'h08;
        tick();
        check("t2_pending", pending, 8'h08);
        for (int k = 1; k <= 14; k++) begin
            request_floor = (k == 11) ? 8'h42 : 8'h00;
            tick();
            if (k == 3)  check("t2_floor1", out_current_floor, 8'h02);
            if (k == 6)  check("t2_floor2", out_current_floor, 8'h04);
            if (k == 9)  check("t2_floor3", out_current_floor, 8'h08);
            if (k == 10) begin
                check("t2_door_on",  door_open, 1'b1);
                check("t2_complete", complete,  1'b1);
                check("t2_cleared",  pending,   8'h00);
            end
            if (k == 11) check("t2_single_pulse", complete, 1'b0);
            if (k == 14) check("t2_door_off", door_open, 1'b0);
        end
        request_floor = 8'h00;
        completes = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (complete) begin
                completes++;
                check("t3_serve_order", out_current_floor, (completes == 1) ? 8'h40 : 8'h02);
            end
        end
        check("t3_completes", completes, 2);
        check("t3_dir_down",  direction, 1'b0);
        check("t3_idle",      {moving, door_open, pending}, 10'h000);

        // obstruction holds the door at floor 1
        request_floor = 8'h02; tick();
        request_floor = 8'h00; tick();
        check("t4_door_on", door_open, 1'b1);
        over_time = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_alert", door_alert, 1'b1);
        end
        over_time = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_held_open", {door_open, door_alert}, 2'b10);
        end
        tick();
        check("t4_closed", door_open, 1'b0);

        // overload holds the door with a call waiting at floor 7
        request_floor = 8'h02; tick();
        request_floor = 8'h00; tick();
        over_weight = 1'b1; request_floor = 8'h80; tick();
        request_floor = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_walert", {weight_alert, door_open, moving}, 3'b110);
        end
        over_weight = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_held_open", door_open, 1'b1);
        end
        tick();
        check("t5_closed", door_open, 1'b0);
        tick();
        check("t5_moving", {moving, direction}, 2'b11);

        // reset in the middle of a move
        request_floor = 8'hF0; tick();
        request_floor = 8'h00;
        check("t6_pending", {pending, moving}, {8'hF0, 1'b1});
        reset = 1'b1; tick();
        reset = 1'b0;
        check("t6_floor",   out_current_floor, 8'h01);
        check("t6_pending_cleared", pending, 8'h00);
        check("t6_stopped", {moving, complete, door_open}, 3'b000);

        // random traffic with sensor noise and occasional reset
        for (int k = 0; k < 3000; k++) begin
            r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            request_floor = ($urandom_range(0, 3) == 0) ? r : 8'h00;
            over_time     = ($urandom_range(0, 9) == 0);
            over_weight   = ($urandom_range(0, 15) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; request_floor = '0; over_time = 1'b0; over_weight = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
